muldiv_ctrl: RTL and testbench

- Sequencer between the multicycle CPU control unit and the iterative multiplier (booth_mult) and divider units.
- Latches operands and pulses the selected unit's reset to start it, then counts the unit's fixed iteration latency.
- Captures the result into the architectural HI/LO registers and signals busy/done to the control unit.
- Detects divide-by-zero before launching the divider.

---
 rtl/muldiv_ctrl.sv | 167 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer between the CPU control unit and the iterative
// multiplier/divider units; owns the architectural HI/LO registers.
// Ports: clock, reset_n (async, active low); start/op/op_a/op_b request;
//   unit_a/unit_b latched operands and mult_rst/div_rst unit starts;
//   mult_hi/mult_lo, div_hi/div_lo unit results; busy/done/div_zero
//   status pulses; hi/lo architectural registers.
// Optional macro MULDIV_HILO_WRITE_EN adds hilo_we/hilo_wdata (MTHI/MTLO).
module muldiv_ctrl #(
   parameter int MULT_CYCLES = 33,
   parameter int DIV_CYCLES  = 33,
   parameter int CNT_W       = 6
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic [31:0] unit_a,
   output logic [31:0] unit_b,
   output logic        mult_rst,
   output logic        div_rst,
   input  logic [31:0] mult_hi,
   input  logic [31:0] mult_lo,
   input  logic [31:0] div_hi,
   input  logic [31:0] div_lo,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
`ifdef MULDIV_HILO_WRITE_EN
   input  logic [1:0]  hilo_we,
   input  logic [31:0] hilo_wdata,
`endif
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_RUN,
      S_CAP,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

   state_t            state_q, state_d;
   logic              op_q, op_d;
   logic              dz_q, dz_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       unit_a_q, unit_a_d;
   logic [31:0]       unit_b_q, unit_b_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              div_zero_q, div_zero_d;
   logic              mult_rst_q, mult_rst_d;
   logic              div_rst_q, div_rst_d;
   logic              unit_live;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      dz_d     = dz_q;
      cnt_d    = cnt_q;
      unit_a_d = unit_a_q;
      unit_b_d = unit_b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      unique case (state_q)
         S_IDLE: begin
`ifdef MULDIV_HILO_WRITE_EN
            if (hilo_we[1]) hi_d = hilo_wdata;
            if (hilo_we[0]) lo_d = hilo_wdata;
`endif
            if (start) begin
               op_d     = op;
               unit_a_d = op_a;
               unit_b_d = op_b;
               dz_d     = op && (op_b == 32'd0);
               state_d  = S_CLR;
            end
         end
         S_CLR: begin
            // A zero divisor spends this cycle and finishes without
            // ever releasing the divider.
            if (dz_q) begin
               state_d = S_DONE;
            end else begin
               cnt_d   = op_q ? DIV_N : MULT_N;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - CNT_1;
            if (cnt_q == CNT_1) state_d = S_CAP;
         end
         S_CAP: begin
            hi_d    = op_q ? div_hi : mult_hi;
            lo_d    = op_q ? div_lo : mult_lo;
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered: derive them from the state being entered.
      unit_live  = (state_d == S_RUN) || (state_d == S_CAP);
      busy_d     = (state_d == S_CLR) || unit_live;
      done_d     = (state_d == S_DONE);
      div_zero_d = (state_d == S_DONE) && dz_q;
      mult_rst_d = !(unit_live && !op_d);
      div_rst_d  = !(unit_live && op_d);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         op_q       <= 1'b0;
         dz_q       <= 1'b0;
         cnt_q      <= '0;
         unit_a_q   <= '0;
         unit_b_q   <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         mult_rst_q <= 1'b1;
         div_rst_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         dz_q       <= dz_d;
         cnt_q      <= cnt_d;
         unit_a_q   <= unit_a_d;
         unit_b_q   <= unit_b_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
         mult_rst_q <= mult_rst_d;
         div_rst_q  <= div_rst_d;
      end
   end

   assign unit_a   = unit_a_q;
   assign unit_b   = unit_b_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign mult_rst = mult_rst_q;
   assign div_rst  = div_rst_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: random and directed stimulus for muldiv_ctrl, with
// behavioural units and a transaction-level timeline reference model.
module tb_muldiv_ctrl;

   localparam int N_MUL = 33;
   localparam int N_DIV = 33;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [31:0] unit_a, unit_b;
   logic        mult_rst, div_rst;
   logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;
`ifdef MULDIV_HILO_WRITE_EN
   logic [1:0]  hilo_we = '0;
   logic [31:0] hilo_wdata = '0;
`endif

   int vectors = 0;
   int miscompares = 0;

   muldiv_ctrl dut (
      .clock(clock), .reset_n(reset_n),
      .start(start), .op(op), .op_a(op_a), .op_b(op_b),
      .unit_a(unit_a), .unit_b(unit_b),
      .mult_rst(mult_rst), .div_rst(div_rst),
      .mult_hi(mult_hi), .mult_lo(mult_lo),
      .div_hi(div_hi), .div_lo(div_lo),
      .busy(busy), .done(done), .div_zero(div_zero),
`ifdef MULDIV_HILO_WRITE_EN
      .hilo_we(hilo_we), .hilo_wdata(hilo_wdata),
`endif
      .hi(hi), .lo(lo)
   );

   always #5 clock = ~clock;

   function automatic logic [63:0] f_mul(input logic [31:0] a, input logic [31:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return p;
   endfunction

   function automatic logic [63:0] f_div(input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Behavioural units: results valid only after 32 cycles out of reset.
   logic [6:0] mcnt, dcnt;
   always @(posedge clock) begin
      if (mult_rst) mcnt <= '0;
      else if (mcnt != 7'd127) mcnt <= mcnt + 7'd1;
      if (div_rst) dcnt <= '0;
      else if (dcnt != 7'd127) dcnt <= dcnt + 7'd1;
   end
   assign {mult_hi, mult_lo} = (mcnt >= 7'd32) ? f_mul(unit_a, unit_b)
                                               : {32'hBAD0BAD0, 25'd0, mcnt};
   assign {div_hi, div_lo} = (dcnt >= 7'd32) ? f_div(unit_a, unit_b)
                                             : {32'hDEADD1F0, 25'd0, dcnt};

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h at t=%0t", nm, got, exp, $time);
      end
   endtask

   // Reference model: a transaction timeline in posedge counts.
   // cyc = number of posedges seen; the interval after edge e has cyc == e.
   int          cyc = 0;
   bit          m_act = 0, m_op = 0, m_dz = 0;
   int          m_k = 0, m_td = 0;
   logic [31:0] m_hi = '0, m_lo = '0, m_ua = '0, m_ub = '0;
   logic [31:0] m_phi = '0, m_plo = '0;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_act = 0;
         m_hi = '0; m_lo = '0; m_ua = '0; m_ub = '0;
      end else begin
         cyc++;
         if (m_act && cyc == m_td && !m_dz) begin
            m_hi = m_phi;
            m_lo = m_plo;
         end
         if (!m_act || cyc >= m_td + 2) begin
`ifdef MULDIV_HILO_WRITE_EN
            if (hilo_we[1]) m_hi = hilo_wdata;
            if (hilo_we[0]) m_lo = hilo_wdata;
`endif
            if (start) begin
               m_act = 1;
               m_op = op;
               m_dz = op && (op_b == 0);
               m_k = cyc;
               m_td = m_dz ? cyc + 1 : cyc + (op ? N_DIV : N_MUL) + 2;
               m_ua = op_a;
               m_ub = op_b;
               {m_phi, m_plo} = op ? f_div(op_a, op_b) : f_mul(op_a, op_b);
            end
         end
      end
   end

   logic e_busy, e_done, e_dz, e_run;
   always @(negedge clock) begin
      e_busy = m_act && cyc >= m_k && cyc < m_td;
      e_done = m_act && cyc == m_td;
      e_dz   = e_done && m_dz;
      e_run  = m_act && !m_dz && cyc >= m_k + 1 && cyc <= m_td - 1;
      chk("ctrl", {59'd0, busy, done, div_zero, mult_rst, div_rst},
          {59'd0, e_busy, e_done, e_dz, !(e_run && !m_op), !(e_run && m_op)});
      chk("hilo", {hi, lo}, {m_hi, m_lo});
      chk("unit", {unit_a, unit_b}, {m_ua, m_ub});
   end

   // Drives one start after 'pre' negedges; returns in the done cycle.
   task automatic run_op(input int pre, input bit o, input logic [31:0] a,
                         input logic [31:0] b, output int d_at,
                         output int b_cnt, output bit dz_seen);
      repeat (pre) @(negedge clock);
      #1;
      start = 1; op = o; op_a = a; op_b = b;
      d_at = 0; b_cnt = 0; dz_seen = 0;
      for (int i = 1; i <= 80 && d_at == 0; i++) begin
         @(negedge clock);
         if (busy) b_cnt++;
         if (done) begin
            d_at = i;
            dz_seen = div_zero;
         end
         #1 start = 0;
      end
   endtask

   int d_at, b_cnt, n_done;
   bit dz_seen;

   initial begin
      #1 reset_n = 0;
      repeat (2) @(negedge clock);
      chk("reset_hilo", {hi, lo}, 64'd0);
      chk("reset_rst", {62'd0, mult_rst, div_rst}, 64'd3);
      #1 reset_n = 1;

      run_op(1, 0, 32'd7, 32'hFFFFFFFD, d_at, b_cnt, dz_seen);
      chk("mul_lat", d_at, 36);
      chk("mul_busy", b_cnt, 35);
      chk("mul_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

      run_op(1, 1, 32'd100, 32'd7, d_at, b_cnt, dz_seen);
      chk("div_lat", d_at, 36);
      chk("div_res", {hi, lo}, {32'd2, 32'd14});
      chk("div_dz", dz_seen, 0);
      @(negedge clock);
      chk("done_1cyc", done, 0);

      run_op(1, 0, 32'd102, 32'h2AAAAAAB, d_at, b_cnt, dz_seen);
      chk("preload", {hi, lo}, {32'h11, 32'h22});
      run_op(1, 1, 32'd55, 32'd0, d_at, b_cnt, dz_seen);
      chk("dz_lat", d_at, 2);
      chk("dz_flag", dz_seen, 1);
      chk("dz_busy", b_cnt, 1);
      chk("dz_hilo", {hi, lo}, {32'h11, 32'h22});

      // start in the DONE cycle is dropped
      start = 1; op = 0; op_a = 32'd3; op_b = 32'd3;
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (done) n_done++;
         #1 start = 0;
      end
      chk("done_start_ign", n_done, 0);

      // starts while running are ignored, then reset mid-run
      start = 1; op = 0; op_a = 32'd1000; op_b = 32'd1000;
      @(negedge clock);
      #1 start = 0;
      repeat (5) @(negedge clock);
      #1 start = 1; op = 1; op_a = 32'd9; op_b = 32'd0;
      @(negedge clock);
      #1 start = 0;
      repeat (16) @(negedge clock);
      chk("run_nodone", done, 0);
      #2 reset_n = 0;
      #1;
      chk("async_busy", {62'd0, busy, done}, 64'd0);
      chk("async_rst", {62'd0, mult_rst, div_rst}, 64'd3);
      chk("async_hilo", {hi, lo}, 64'd0);
      chk("async_unit", {unit_a, unit_b}, 64'd0);
      repeat (2) @(negedge clock);
      #1 reset_n = 1;
      run_op(1, 0, 32'd5, 32'd6, d_at, b_cnt, dz_seen);
      chk("post_rst_lat", d_at, 36);
      chk("post_rst_res", {hi, lo}, {32'd0, 32'd30});

      // back to back: second start in the cycle after done
      run_op(1, 1, 32'hFFFFFFCE, 32'd7, d_at, b_cnt, dz_seen);
      chk("b2b_lat", d_at, 36);
      chk("b2b_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFF9);

`ifdef MULDIV_HILO_WRITE_EN
      @(negedge clock);
      #1 hilo_we = 2'b10; hilo_wdata = 32'hCAFEF00D;
      @(negedge clock);
      #1 hilo_we = 2'b00;
      chk("mthi", {hi, lo}, 64'hCAFEF00D_FFFFFFF9);
      start = 1; op = 0; op_a = 32'd9; op_b = 32'd9;
      @(negedge clock);
      #1 start = 0;
      repeat (10) @(negedge clock);
      #1 hilo_we = 2'b10; hilo_wdata = 32'h12345678;
      @(negedge clock);
      #1 hilo_we = 2'b00;
      d_at = 0;
      for (int i = 0; i < 60 && d_at == 0; i++) begin
         @(negedge clock);
         if (done) d_at = 1;
      end
      chk("we_busy_done", d_at, 1);
      chk("we_busy_ign", {hi, lo}, {32'd0, 32'd81});
`endif

      // random phase
      for (int i = 0; i < 2500; i++) begin
         @(negedge clock);
         #1;
         start = ($urandom_range(0, 5) == 0);
         op = 1'($urandom_range(0, 1));
         op_a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300)) - 32'd150
                                            : 32'($urandom);
         op_b = ($urandom_range(0, 5) == 0) ? 32'd0
              : ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 40))
                                            : 32'($urandom);
`ifdef MULDIV_HILO_WRITE_EN
         hilo_we = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         hilo_wdata = 32'($urandom);
`endif
      end
      @(negedge clock);
      #1 start = 0;
`ifdef MULDIV_HILO_WRITE_EN
      hilo_we = 2'b00;
`endif
      repeat (50) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
